fifo_rd_packer: RTL

//  Read-side consumer of the async FIFO, sitting in the rd_clk domain directly after the FIFO's data_out/empty/rd_en port.

---
 rtl/fifo_pkg.sv | 30 +++
 rtl/fifo_pack_idle_ctr.sv | 58 +++++
 rtl/fifo_rd_packer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side packer: default widths, clog2 helper
// and the lane/word helper types.
package fifo_pkg;

   localparam int DATA_WIDTH = 8;
   localparam int ADD_WIDTH  = 4;
   localparam int LANES      = 4;

   function automatic int clog2(input int value);
      int res;
      int pow;
      res = 0;
      pow = 1;
      for (int i = 0; i < 31; i++) begin
         if (pow < value) begin
            res = res + 1;
            pow = pow * 2;
         end
      end
      return res;
   endfunction

   localparam int LANE_CNT_W = clog2(LANES + 1);
   localparam int KEEP_W     = LANES;

   typedef logic [DATA_WIDTH-1:0]       lane_t;
   typedef logic [LANES*DATA_WIDTH-1:0] word_t;
   typedef logic [KEEP_W-1:0]           keep_t;

endpackage

// File: rtl/fifo_pack_idle_ctr.sv
// Idle timeout counter for partial-word flushing; only built when FIFO_PACK_FLUSH_EN
// is defined. Counts while a partial word sits with no pop and the FIFO empty.
`ifdef FIFO_PACK_FLUSH_EN
module fifo_pack_idle_ctr
   import fifo_pkg::*;
#(
   parameter int lanes          = LANES,
   parameter int cnt_w          = LANE_CNT_W,
   parameter int timeout_cycles = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [cnt_w-1:0] acc_cnt,
   input  logic             pop_q,
   input  logic             fifo_empty,
   input  logic             clear,
   output logic             idle_done
);

   localparam int              TW        = clog2(timeout_cycles + 1);
   localparam logic [TW-1:0]   LIMIT     = TW'(timeout_cycles);
   localparam logic [cnt_w-1:0] FULL_CNT = cnt_w'(lanes);

   logic [TW-1:0] idle_cnt_r;
   logic [TW-1:0] idle_cnt_next_s;
   logic          idle_done_r;
   logic          idle_cond_s;

   // Next counter value: saturate at the limit, clear on any activity or flush
   always_comb begin
      idle_cond_s     = (acc_cnt != {cnt_w{1'b0}}) && (acc_cnt < FULL_CNT) && !pop_q && fifo_empty;
      idle_cnt_next_s = idle_cnt_r;
      if (clear) begin
         idle_cnt_next_s = {TW{1'b0}};
      end else if (!idle_cond_s) begin
         idle_cnt_next_s = {TW{1'b0}};
      end else if (idle_cnt_r != LIMIT) begin
         idle_cnt_next_s = idle_cnt_r + {{(TW-1){1'b0}}, 1'b1};
      end else begin
         idle_cnt_next_s = idle_cnt_r;
      end
   end

   // Counter and registered timeout flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idle_cnt_r  <= {TW{1'b0}};
         idle_done_r <= 1'b0;
      end else begin
         idle_cnt_r  <= idle_cnt_next_s;
         idle_done_r <= (idle_cnt_next_s == LIMIT);
      end
   end

   assign idle_done = idle_done_r;

endmodule
`endif

// File: rtl/fifo_rd_packer.sv
// Read-side FIFO consumer: pops entries, packs `lanes` of them into one word and
// presents it on a valid/ready stream. Optional idle flush under FIFO_PACK_FLUSH_EN.
module fifo_rd_packer
   import fifo_pkg::*;
#(
   parameter int data_width     = DATA_WIDTH,
   parameter int lanes          = LANES,
   parameter int timeout_cycles = 16
) (
   input  logic                        rd_clk,
   input  logic                        rd_rst,
   input  logic                        fifo_empty,
   input  logic [data_width-1:0]       fifo_data,
   output logic                        fifo_rd_en,
   output logic [lanes*data_width-1:0] m_data,
   output logic [lanes-1:0]            m_keep,
   output logic                        m_valid,
   input  logic                        m_ready
);

   localparam int             CW       = clog2(lanes + 1);
   localparam logic [CW:0]    LANES_X  = (CW+1)'(lanes);
   localparam logic [CW-1:0]  LAST_IDX = CW'(lanes - 1);
   localparam logic [CW-1:0]  FULL_CNT = CW'(lanes);

   if (lanes < 2 || timeout_cycles < 1) begin : g_cfg_check
      $error("fifo_rd_packer: lanes must be >= 2 and timeout_cycles >= 1");
   end

   logic [data_width-1:0]       acc_r [lanes];
   logic [CW-1:0]               acc_cnt_r;
   logic                        pop_q_r;
   logic [lanes*data_width-1:0] m_data_r;
   logic [lanes-1:0]            m_keep_r;
   logic                        m_valid_r;

   logic                        out_free_s;
   logic                        complete_s;
   logic                        load_s;
   logic                        flush_s;
   logic [lanes*data_width-1:0] word_s;
   logic [lanes-1:0]            fill_keep_s;

   assign out_free_s = !m_valid_r || m_ready;
   assign complete_s = ((acc_cnt_r == LAST_IDX) && pop_q_r) || (acc_cnt_r == FULL_CNT);
   assign load_s     = complete_s && out_free_s;

   // Pop whenever the entry in flight still fits, or the output can take a word now
   always_comb begin
      fifo_rd_en = 1'b0;
      if (rd_rst) begin
         fifo_rd_en = 1'b0;
      end else if (fifo_empty) begin
         fifo_rd_en = 1'b0;
      end else if (({1'b0, acc_cnt_r} + {{CW{1'b0}}, pop_q_r}) < LANES_X) begin
         fifo_rd_en = 1'b1;
      end else if (out_free_s) begin
         fifo_rd_en = 1'b1;
      end else begin
         fifo_rd_en = 1'b0;
      end
   end

   // Candidate word: stored lanes plus the arriving entry; unfilled lanes read as zero
   always_comb begin
      word_s      = {(lanes*data_width){1'b0}};
      fill_keep_s = {lanes{1'b0}};
      for (int i = 0; i < lanes; i++) begin
         fill_keep_s[i] = (CW'(i) < acc_cnt_r);
         if (pop_q_r && (CW'(i) == acc_cnt_r)) begin
            word_s[i*data_width +: data_width] = fifo_data;
         end else if (CW'(i) < acc_cnt_r) begin
            word_s[i*data_width +: data_width] = acc_r[i];
         end else begin
            word_s[i*data_width +: data_width] = {data_width{1'b0}};
         end
      end
   end

`ifdef FIFO_PACK_FLUSH_EN
   logic idle_done_s;

   fifo_pack_idle_ctr #(
      .lanes          (lanes),
      .cnt_w          (CW),
      .timeout_cycles (timeout_cycles)
   ) u_idle_ctr (
      .clk        (rd_clk),
      .rst        (rd_rst),
      .acc_cnt    (acc_cnt_r),
      .pop_q      (pop_q_r),
      .fifo_empty (fifo_empty),
      .clear      (flush_s),
      .idle_done  (idle_done_s)
   );

   assign flush_s = idle_done_s && out_free_s && !pop_q_r &&
                    (acc_cnt_r != {CW{1'b0}}) && (acc_cnt_r < FULL_CNT);
`else
   assign flush_s = 1'b0;
`endif

   // Accumulator: pop tracking, lane fill count and lane storage
   always_ff @(posedge rd_clk or posedge rd_rst) begin
      if (rd_rst) begin
         pop_q_r   <= 1'b0;
         acc_cnt_r <= {CW{1'b0}};
         for (int i = 0; i < lanes; i++) begin
            acc_r[i] <= {data_width{1'b0}};
         end
      end else begin
         pop_q_r <= fifo_rd_en;
         if (load_s || flush_s) begin
            acc_cnt_r <= {CW{1'b0}};
         end else if (complete_s) begin
            acc_cnt_r <= FULL_CNT;
         end else if (pop_q_r) begin
            acc_cnt_r <= acc_cnt_r + {{(CW-1){1'b0}}, 1'b1};
         end else begin
            acc_cnt_r <= acc_cnt_r;
         end
         for (int i = 0; i < lanes; i++) begin
            if (pop_q_r && (CW'(i) == acc_cnt_r)) begin
               acc_r[i] <= fifo_data;
            end
         end
      end
   end

   // Output stage: load a full or flushed word, otherwise hold until accepted
   always_ff @(posedge rd_clk or posedge rd_rst) begin
      if (rd_rst) begin
         m_valid_r <= 1'b0;
         m_data_r  <= {(lanes*data_width){1'b0}};
         m_keep_r  <= {lanes{1'b0}};
      end else if (load_s) begin
         m_valid_r <= 1'b1;
         m_data_r  <= word_s;
         m_keep_r  <= {lanes{1'b1}};
      end else if (flush_s) begin
         m_valid_r <= 1'b1;
         m_data_r  <= word_s;
         m_keep_r  <= fill_keep_s;
      end else if (m_ready) begin
         m_valid_r <= 1'b0;
      end else begin
         m_valid_r <= m_valid_r;
      end
   end

   assign m_valid = m_valid_r;
   assign m_data  = m_data_r;
   assign m_keep  = m_keep_r;

endmodule
